// File: rtl/approx_error_monitor.sv
// approx_error_monitor
// Exhaustive error evaluator for an approximate combinational adder.
// Walks every input vector, compares the adder output against the exact
// sum and accumulates worst-case, count and total absolute error, then
// reports pass/fail against the error threshold ET.

module approx_error_monitor #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int ET    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        vec_out,
    input  logic [N_OUT-1:0]       dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_OUT-1:0]       max_err,
    output logic [N_IN:0]          err_count,
    output logic [N_IN+N_OUT-1:0]  sum_err,
    output logic                   fail_valid,
    output logic [N_IN-1:0]        fail_vec
);

    localparam int HALF    = N_IN / 2;
    localparam int ERR_MAX = (1 << N_OUT) - 1;

    // Threshold clipped to the error range so an oversized ET simply means
    // "never exceeded" instead of truncating to a misleading small value.
    localparam logic [N_OUT-1:0] ET_SAT =
        (ET >= ERR_MAX) ? ERR_MAX[N_OUT-1:0] : ET[N_OUT-1:0];

    // Elaboration-time guards on the operand split and output width.
    generate
        if ((N_IN % 2) != 0) begin : g_bad_n_in
            $error("approx_error_monitor: N_IN must be even");
        end
        if (N_OUT != HALF + 1) begin : g_bad_n_out
            $error("approx_error_monitor: N_OUT must equal N_IN/2+1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [N_IN-1:0]       r_vec;
    logic                  r_pass;
    logic [N_OUT-1:0]      r_max_err;
    logic [N_IN:0]         r_err_count;
    logic [N_IN+N_OUT-1:0] r_sum_err;
    logic                  r_fail_valid;
    logic [N_IN-1:0]       r_fail_vec;

    logic [HALF-1:0]  w_a;
    logic [HALF-1:0]  w_b;
    logic [N_OUT-1:0] w_exact;
    logic [N_OUT-1:0] w_err;
    logic [N_OUT-1:0] w_max_next;
    logic             w_err_nz;
    logic             w_over_et;
    logic             w_last;

    // Error of the vector currently presented to the approximate adder.
    always_comb begin
        w_a        = r_vec[HALF-1:0];
        w_b        = r_vec[N_IN-1:HALF];
        w_exact    = N_OUT'(w_a) + N_OUT'(w_b);
        w_err      = (dut_out >= w_exact) ? (dut_out - w_exact) : (w_exact - dut_out);
        w_max_next = (w_err > r_max_err) ? w_err : r_max_err;
        w_err_nz   = (w_err != '0);
        w_over_et  = (w_err > ET_SAT);
        w_last     = &r_vec;
    end

    // State register; rst wins over everything, discarding any run in flight.
    always_ff @(posedge clk) begin
        // NOTE: registers are assigned with <= so every flop samples the
        // pre-edge values of its peers; blocking here would chain updates.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Vector sweep and error statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec        <= '0;
            r_pass       <= 1'b0;
            r_max_err    <= '0;
            r_err_count  <= '0;
            r_sum_err    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Accepting start clears the previous run's results.
                    if (start) begin
                        r_vec        <= '0;
                        r_pass       <= 1'b0;
                        r_max_err    <= '0;
                        r_err_count  <= '0;
                        r_sum_err    <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= '0;
                    end
                end
                S_RUN: begin
                    r_max_err   <= w_max_next;
                    r_err_count <= r_err_count + (N_IN + 1)'(w_err_nz);
                    r_sum_err   <= r_sum_err + (N_IN + N_OUT)'(w_err);
                    // Only the first offending vector is kept so software can
                    // abort early and still know where the bound first broke.
                    if (w_over_et && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_vec   <= r_vec;
                    end
                    if (w_last) begin
                        // Verdict uses the max including this final vector.
                        r_pass <= (w_max_next <= ET_SAT);
                    end else begin
                        r_vec <= r_vec + N_IN'(1);
                    end
                end
                default: begin
                    // DONE: results hold until the next accepted start.
                end
            endcase
        end
    end

    assign vec_out    = r_vec;
    assign pass       = r_pass;
    assign max_err    = r_max_err;
    assign err_count  = r_err_count;
    assign sum_err    = r_sum_err;
    assign fail_valid = r_fail_valid;
    assign fail_vec   = r_fail_vec;

endmodule
